// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the fetch granule, the default boot PC and the queue entry layout.
package fetch_pkg;

   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry queue with flush; head visible the cycle after push.
// Push when full is accepted only alongside a pop; pop when empty is ignored.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   // Storage needs no reset: head is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/prefetch_unit.sv
// Sequential instruction prefetcher: issues PCs to memory, queues responses for decode.
// Response visible one edge after arrival; issue is credit-limited to DEPTH (inflight + queued).
module prefetch_unit
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    DEPTH       = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stallF,
   input  logic                   redirect,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   output logic                   imem_req_valid,
   output logic [ADDR_WIDTH-1:0]  imem_req_addr,
   input  logic                   imem_req_ready,
   input  logic                   imem_resp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_resp_data,
   output logic                   validF,
   output logic [ADDR_WIDTH-1:0]  pcF,
   output logic [INSTR_WIDTH-1:0] instrF
);

   localparam int                    CW      = $clog2(DEPTH) + 1;
   localparam int                    EW      = ADDR_WIDTH + INSTR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(INSTR_BYTES);
   localparam logic [CW:0]           CREDITS = (CW+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] resp_pc;
   logic [CW-1:0]         inflight;
   logic [CW-1:0]         stale;
   logic [CW-1:0]         count;
   logic [EW-1:0]         head;
   logic                  credit_ok;
   logic                  req_fire;
   logic                  resp_ok;
   logic                  push;
   logic                  pop;

   // Every outstanding request owns a queue slot, so a push can never find the queue full.
   assign credit_ok      = ({1'b0, inflight} + {1'b0, count}) < CREDITS;
   assign imem_req_valid = rst && !redirect && credit_ok;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a memory protocol error and is ignored.
   assign resp_ok = imem_resp_valid && (inflight != '0);
   assign push    = resp_ok && (stale == '0) && !redirect;
   assign pop     = validF && !stallF && !redirect;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         stale    <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         resp_pc  <= redirect_pc;
         inflight <= inflight - CW'(resp_ok);
         stale    <= inflight - CW'(resp_ok);
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + STEP;
         if (resp_ok) begin
            if (stale != '0) stale   <= stale - CW'(1);
            else             resp_pc <= resp_pc + STEP;
         end
         inflight <= inflight + CW'(req_fire) - CW'(resp_ok);
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({resp_pc, imem_resp_data}),
      .pop       (pop),
      .flush     (redirect),
      .count     (count),
      .head      (head)
   );

   assign validF = (count != '0);
   assign pcF    = validF ? head[EW-1:INSTR_WIDTH] : '0;
   assign instrF = validF ? head[INSTR_WIDTH-1:0]  : '0;

endmodule

// File: tb/tb_prefetch_unit.sv
// Randomised bench for prefetch_unit: in-order variable-latency memory plus a
// queue-level reference model of what decode should see.
module tb_prefetch_unit;
   import fetch_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = RESET_PC_DEFAULT;

   logic        clk;
   logic        rst;
   logic        stallF;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        validF;
   logic [31:0] pcF;
   logic [31:0] instrF;

   prefetch_unit #(
      .ADDR_WIDTH  (32),
      .INSTR_WIDTH (32),
      .DEPTH       (DEPTH),
      .RESET_PC    (RPC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stallF          (stallF),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .validF          (validF),
      .pcF             (pcF),
      .instrF          (instrF)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          live;
   } pend_t;

   pend_t        pending[$];   // requests accepted by memory, oldest first
   fetch_entry_t q[$];         // instructions decode should see, head first
   logic [31:0]  seen[$];
   logic [31:0]  fetch_pc;
   int           cyc;
   int           n_cmp;
   int           n_err;
   int           fires;
   int           vcnt;
   bit           last_valid;

   int          lat_min, lat_max, ready_pct, stall_pct, redir_pm;
   bit          force_stall, force_redir, spur;
   logic [31:0] force_pc;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic run_cycle();
      pend_t e;
      bit    rd, resp, exp_req, pop_ok;
      @(negedge clk);
      last_valid = validF;
      check_eq("validF", validF, q.size() > 0);
      if (q.size() > 0) begin
         check_eq("pcF", pcF, q[0].pc);
         check_eq("instrF", instrF, q[0].instr);
      end else begin
         check_eq("pcF_idle", pcF, 0);
         check_eq("instrF_idle", instrF, 0);
      end
      if (validF) begin
         seen.push_back(pcF);
         if (cyc >= 2) vcnt++;
      end

      stallF = force_stall || ($urandom_range(99) < stall_pct);
      rd = force_redir || ($urandom_range(999) < redir_pm);
      redirect = rd;
      if (force_redir)                   redirect_pc = force_pc;
      else if ($urandom_range(3) == 0)   redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4);
      else                               redirect_pc = $urandom & 32'hFFFF_FFFC;
      imem_req_ready = ($urandom_range(99) < ready_pct);
      resp = (pending.size() > 0) && (pending[0].due <= cyc);
      imem_resp_valid = resp || (spur && pending.size() == 0);
      imem_resp_data  = resp ? mem_data(pending[0].addr) : $urandom;
      #1;
      exp_req = !rd && (pending.size() + q.size() < DEPTH);
      check_eq("req_valid", imem_req_valid, exp_req);
      check_eq("req_addr", imem_req_addr, fetch_pc);

      pop_ok = (q.size() > 0) && !stallF && !rd;
      if (resp) begin
         e = pending.pop_front();
         if (e.live && !rd) q.push_back('{pc: e.addr, instr: mem_data(e.addr)});
      end
      if (pop_ok) void'(q.pop_front());
      if (rd) begin
         q.delete();
         foreach (pending[i]) pending[i].live = 1'b0;
         fetch_pc = redirect_pc;
      end else if (exp_req && imem_req_ready) begin
         pending.push_back('{addr: fetch_pc, due: cyc + $urandom_range(lat_max, lat_min), live: 1'b1});
         fetch_pc += 32'd4;
         fires++;
      end
      cyc++;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2;
      rst             = 1'b0;
      redirect        = 1'b0;
      stallF          = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      #1;
      check_eq("rst_validF", validF, 0);
      check_eq("rst_pcF", pcF, 0);
      check_eq("rst_instrF", instrF, 0);
      check_eq("rst_req_valid", imem_req_valid, 0);
      check_eq("rst_req_addr", imem_req_addr, RPC);
      pending.delete();
      q.delete();
      fetch_pc = RPC;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      cyc = 0;
   endtask

   task automatic set_mode(input int lmin, input int lmax, input int rdy, input int stl, input int rpm);
      lat_min = lmin; lat_max = lmax; ready_pct = rdy; stall_pct = stl; redir_pm = rpm;
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      force_redir = 1'b1;
      force_pc    = pc;
      run_cycle();
      force_redir = 1'b0;
      seen.delete();
      run_cycle();
      check_eq("redir_flush", last_valid, 0);
   endtask

   initial begin
      rst = 1'b0; stallF = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      n_cmp = 0; n_err = 0; cyc = 0; fires = 0; vcnt = 0; last_valid = 0;
      force_stall = 0; force_redir = 0; spur = 0; force_pc = '0;
      fetch_pc = RPC;
      set_mode(1, 1, 100, 0, 0);

      // Streaming at latency 1: continuous output from cycle 2 onward.
      apply_reset();
      vcnt = 0;
      repeat (20) run_cycle();
      check_eq("throughput", vcnt, 18);

      // Stall from reset: exactly DEPTH requests, then back-to-back drain.
      apply_reset();
      fires = 0;
      force_stall = 1'b1;
      repeat (10) run_cycle();
      check_eq("stall_fires", fires, DEPTH);
      check_eq("stall_head", pcF, RPC);
      force_stall = 1'b0;
      seen.delete();
      repeat (4) run_cycle();
      check_eq("drain_len", seen.size(), 4);
      for (int i = 0; i < 4 && i < seen.size(); i++)
         check_eq("drain_pc", seen[i], RPC + 32'(4 * i));

      // Redirect with a response arriving and another still outstanding.
      apply_reset();
      set_mode(4, 4, 100, 0, 0);
      force_stall = 1'b1;
      repeat (6) run_cycle();
      force_stall = 1'b0;
      set_mode(1, 1, 100, 0, 0);
      do_redirect(32'h0000_0100);
      repeat (8) run_cycle();
      check_eq("redir_first_pc", (seen.size() > 0) ? seen[0] : 32'hDEAD_BEEF, 32'h0000_0100);

      // Redirect coinciding with a response and a pop in steady streaming.
      apply_reset();
      repeat (6) run_cycle();
      do_redirect(32'h0000_0200);
      repeat (8) run_cycle();
      check_eq("redir2_first_pc", (seen.size() > 0) ? seen[0] : 32'hDEAD_BEEF, 32'h0000_0200);

      // Address wrap at the top of memory.
      do_redirect(32'hFFFF_FFF8);
      repeat (8) run_cycle();
      check_eq("wrap_len_ok", seen.size() >= 3, 1);
      if (seen.size() >= 3) begin
         check_eq("wrap_pc0", seen[0], 32'hFFFF_FFF8);
         check_eq("wrap_pc1", seen[1], 32'hFFFF_FFFC);
         check_eq("wrap_pc2", seen[2], 32'h0000_0000);
      end

      // Spurious response with nothing outstanding must be ignored.
      apply_reset();
      set_mode(1, 1, 0, 0, 0);
      spur = 1'b1;
      run_cycle();
      spur = 1'b0;
      repeat (2) run_cycle();
      set_mode(1, 1, 100, 0, 0);
      repeat (10) run_cycle();

      // Random traffic with a reset dropped into the middle of it.
      apply_reset();
      set_mode(1, 5, 70, 30, 30);
      repeat (1500) run_cycle();
      apply_reset();
      repeat (1500) run_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
